// File: rtl/dkong_debug_pkg.sv
// Shared types and constants for the dkong debug stream transmitter.
// Holds the bit-level and frame-level state encodings and the frame length helper.
package dkong_debug_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    typedef enum logic {FRAME_IDLE, FRAME_SEND} frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Bytes per frame: sync, sequence number, channels, checksum.
    function automatic int frame_len(input int num_ch);
        return num_ch + 3;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, each bit held CLKS_PER_BIT cycles.
// Handshake: a byte is accepted on any cycle where load && ready are both high.
// ready is high in IDLE and on the final cycle of STOP, so a new byte loaded
// then begins its start bit with no idle gap.
module uart_tx_byte
    import dkong_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       ser_out,
    output tx_state_t  state_dbg
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shreg, shreg_next;
    logic             bit_end;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shreg    <= shreg_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_next  = bit_idx;
        shreg_next    = shreg;
        ready         = 1'b0;
        ser_out       = 1'b1;
        case (state)
            IDLE: begin
                ready         = 1'b1;
                baud_cnt_next = '0;
            end
            START: begin
                ser_out = 1'b0;
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                ser_out = shreg[bit_idx];
                if (bit_end) begin
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_idx_next = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    ready      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load && ready) begin
            state_next    = START;
            shreg_next    = data;
            baud_cnt_next = '0;
        end
    end

endmodule

// File: rtl/dkong_debug_stream_tx.sv
// Snapshots NUM_CH debug bytes and sends them as a framed 8N1 stream:
// SYNC_BYTE, seq, ch[0]..ch[NUM_CH-1], CSUM, with back-to-back frame support.
module dkong_debug_stream_tx
    import dkong_debug_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 1,
    parameter int          NUM_CH       = 6,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                masterclk,
    input  logic                rst_n,
    input  logic [NUM_CH*8-1:0] ch_data,
    input  logic                trig,
    input  logic                cont_mode,
    output logic                busy,
    output logic [7:0]          seq,
    output logic                ser_out,
    output tx_state_t           dbg_tx_state,
    output frame_state_t        dbg_frame_state
);

    localparam int FRAME_LEN = frame_len(NUM_CH);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    frame_state_t        frame_state, frame_state_next;
    logic [IDX_W-1:0]    byte_idx, byte_idx_next, nxt_idx;
    logic [7:0]          seq_next;
    logic                pending, pending_next;
    logic [NUM_CH*8-1:0] snap_ch;
    logic [7:0]          snap_seq, snap_csum, csum_next;
    logic                start_req, take_snap;
    logic                tx_load, tx_ready;
    logic [7:0]          tx_byte, mux_byte;

    assign start_req       = trig | pending | cont_mode;
    assign busy            = (frame_state == FRAME_SEND);
    assign nxt_idx         = byte_idx + IDX_W'(1);
    assign dbg_frame_state = frame_state;

    always_ff @(posedge masterclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_state <= FRAME_IDLE;
            byte_idx    <= '0;
            seq         <= '0;
            pending     <= 1'b0;
        end else begin
            frame_state <= frame_state_next;
            byte_idx    <= byte_idx_next;
            seq         <= seq_next;
            pending     <= pending_next;
        end
    end

    always_comb begin
        frame_state_next = frame_state;
        byte_idx_next    = byte_idx;
        seq_next         = seq;
        take_snap        = 1'b0;
        tx_load          = 1'b0;
        tx_byte          = SYNC_BYTE;
        case (frame_state)
            FRAME_IDLE: begin
                if (start_req) begin
                    take_snap        = 1'b1;
                    tx_load          = 1'b1;
                    byte_idx_next    = '0;
                    frame_state_next = FRAME_SEND;
                end
            end
            FRAME_SEND: begin
                if (tx_ready) begin
                    if (byte_idx != LAST_IDX) begin
                        tx_load       = 1'b1;
                        tx_byte       = mux_byte;
                        byte_idx_next = nxt_idx;
                    end else begin
                        // Frame done: the next frame (if any) starts on this same edge.
                        seq_next      = seq + 8'd1;
                        byte_idx_next = '0;
                        if (start_req) begin
                            take_snap = 1'b1;
                            tx_load   = 1'b1;
                        end else begin
                            frame_state_next = FRAME_IDLE;
                        end
                    end
                end
            end
            default: frame_state_next = FRAME_IDLE;
        endcase
        if (take_snap)                           pending_next = 1'b0;
        else if (frame_state == FRAME_SEND && trig) pending_next = 1'b1;
        else                                     pending_next = pending;
    end

    // Checksum covers the sequence number that the new frame will carry.
    always_comb begin
        csum_next = seq_next;
        for (int i = 0; i < NUM_CH; i++) csum_next = csum_next + ch_data[i*8 +: 8];
    end

    always_comb begin
        mux_byte = snap_csum;
        if (nxt_idx == IDX_W'(1)) mux_byte = snap_seq;
        for (int i = 0; i < NUM_CH; i++) begin
            if (nxt_idx == IDX_W'(i + 2)) mux_byte = snap_ch[i*8 +: 8];
        end
    end

    always_ff @(posedge masterclk or negedge rst_n) begin
        if (!rst_n) begin
            snap_ch   <= '0;
            snap_seq  <= '0;
            snap_csum <= '0;
        end else if (take_snap) begin
            snap_ch   <= ch_data;
            snap_seq  <= seq_next;
            snap_csum <= csum_next;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (masterclk),
        .rst_n     (rst_n),
        .load      (tx_load),
        .data      (tx_byte),
        .ready     (tx_ready),
        .ser_out   (ser_out),
        .state_dbg (dbg_tx_state)
    );

endmodule

// File: tb/tb_dkong_debug_stream_tx.sv
// Directed bench for dkong_debug_stream_tx: decodes the UART line and checks
// frame bytes, busy length, seq progression, triggering modes and reset abort.
module tb_dkong_debug_stream_tx;
    import dkong_debug_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  ch4, ch1;
    logic         trig4, trig1, cont4, cont1;
    logic         busy4, busy1, ser4, ser1;
    logic [7:0]   seq4, seq1;
    tx_state_t    st4, st1;
    frame_state_t fs4, fs1;

    int n_assert = 0;
    int n_fail = 0;
    int busy_cnt4 = 0;
    int busy_cnt1 = 0;
    int b0;
    int n;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    dkong_debug_stream_tx #(.CLKS_PER_BIT(4), .NUM_CH(2), .SYNC_BYTE(8'hA5)) dut4 (
        .masterclk(clk), .rst_n(rst_n), .ch_data(ch4), .trig(trig4), .cont_mode(cont4),
        .busy(busy4), .seq(seq4), .ser_out(ser4), .dbg_tx_state(st4), .dbg_frame_state(fs4)
    );

    dkong_debug_stream_tx #(.CLKS_PER_BIT(1), .NUM_CH(2), .SYNC_BYTE(8'hA5)) dut1 (
        .masterclk(clk), .rst_n(rst_n), .ch_data(ch1), .trig(trig1), .cont_mode(cont1),
        .busy(busy1), .seq(seq1), .ser_out(ser1), .dbg_tx_state(st1), .dbg_frame_state(fs1)
    );

    // clock / busy-cycle counters
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy4) busy_cnt4++;
        if (busy1) busy_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ser_sel(input int which);
        return (which == 1) ? ser1 : ser4;
    endfunction

    task automatic push_frame(input logic [7:0] s, input logic [7:0] c0,
                              input logic [7:0] c1, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(cs);
    endtask

    // Decode nbytes contiguous 8N1 bytes; must be called just after a negedge.
    task automatic recv_bytes(input int which, input int nbytes);
        int cpb;
        int w;
        logic [7:0] b;
        logic s;
        cpb = (which == 1) ? 1 : 4;
        w = 0;
        b = '0;
        while (ser_sel(which) !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        check("start_wait", 32'(w < 4000), 32'd1);
        if (w >= 4000) return;
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 10; j++) begin
                s = ser_sel(which);
                if (j == 0)      check("start_bit", 32'(s), 32'd0);
                else if (j == 9) check("stop_bit", 32'(s), 32'd1);
                else             b[j-1] = s;
                repeat (cpb) @(negedge clk);
            end
            rx_q.push_back(b);
        end
    endtask

    task automatic compare_rx(input string tag);
        logic [7:0] e, r;
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            check(tag, 32'(r), 32'(e));
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic start_frame(input int which);
        @(posedge clk); #1;
        if (which == 1) trig1 = 1'b1; else trig4 = 1'b1;
        @(posedge clk); #1;
        trig1 = 1'b0;
        trig4 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        ch4 = 16'h3412; ch1 = 16'h2211;
        trig4 = 1'b0; trig1 = 1'b0; cont4 = 1'b0; cont1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ser4", 32'(ser4), 32'd1);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_seq4", 32'(seq4), 32'd0);
        check("rst_ser1", 32'(ser1), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_seq1", 32'(seq1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // one-shot frame, latency, busy length, snapshot isolation
        @(posedge clk); #1;
        trig4 = 1'b1;
        b0 = busy_cnt4;
        @(negedge clk);
        check("lat_ser_T", 32'(ser4), 32'd1);
        check("lat_busy_T", 32'(busy4), 32'd0);
        @(posedge clk); #1;
        trig4 = 1'b0;
        @(negedge clk);
        check("lat_ser_T1", 32'(ser4), 32'd0);
        check("lat_busy_T1", 32'(busy4), 32'd1);
        fork
            recv_bytes(0, 5);
            begin
                repeat (60) @(negedge clk);
                ch4 = 16'hFFFF;
            end
        join
        push_frame(8'h00, 8'h12, 8'h34, 8'h46);
        compare_rx("frame0");
        check("f0_busy_len", 32'(busy_cnt4 - b0), 32'd200);
        check("f0_busy_end", 32'(busy4), 32'd0);
        check("f0_ser_idle", 32'(ser4), 32'd1);
        check("f0_seq", 32'(seq4), 32'd1);

        // second trig picks up the new channel values
        repeat (5) @(negedge clk);
        start_frame(0);
        recv_bytes(0, 5);
        push_frame(8'h01, 8'hFF, 8'hFF, 8'hFF);
        compare_rx("frame1");
        check("f1_seq", 32'(seq4), 32'd2);

        // continuous mode, three contiguous frames at one clock per bit
        @(posedge clk); #1;
        cont1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        fork
            recv_bytes(1, 15);
            begin
                repeat (120) @(negedge clk);
                cont1 = 1'b0;
            end
        join
        push_frame(8'h00, 8'h11, 8'h22, 8'h33);
        push_frame(8'h01, 8'h11, 8'h22, 8'h34);
        push_frame(8'h02, 8'h11, 8'h22, 8'h35);
        compare_rx("cont");
        repeat (5) @(negedge clk);
        check("cont_busy_end", 32'(busy1), 32'd0);
        check("cont_seq", 32'(seq1), 32'd3);

        // three triggers during one frame give exactly one extra frame
        ch4 = 16'h0201;
        repeat (5) @(negedge clk);
        b0 = busy_cnt4;
        start_frame(0);
        fork
            recv_bytes(0, 10);
            begin
                repeat (3) begin
                    repeat (20) @(negedge clk);
                    trig4 = 1'b1;
                    @(negedge clk);
                    trig4 = 1'b0;
                end
            end
        join
        push_frame(8'h02, 8'h01, 8'h02, 8'h05);
        push_frame(8'h03, 8'h01, 8'h02, 8'h06);
        compare_rx("pend");
        check("pend_busy_end", 32'(busy4), 32'd0);
        repeat (50) @(negedge clk);
        check("pend_busy_len", 32'(busy_cnt4 - b0), 32'd400);
        check("pend_seq", 32'(seq4), 32'd4);
        check("pend_ser_idle", 32'(ser4), 32'd1);

        // run seq up to 255, then check the wrap and checksum wrap
        @(posedge clk); #1;
        cont1 = 1'b1;
        n = 0;
        while (seq1 !== 8'd254 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("seq_run_wait", 32'(n < 20000), 32'd1);
        cont1 = 1'b0;
        n = 0;
        while (busy1 !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("seq_idle_wait", 32'(n < 200), 32'd1);
        check("seq_at_ff", 32'(seq1), 32'hFF);
        ch1 = 16'h8080;
        @(posedge clk); #1;
        cont1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        fork
            recv_bytes(1, 10);
            begin
                repeat (60) @(negedge clk);
                cont1 = 1'b0;
            end
        join
        push_frame(8'hFF, 8'h80, 8'h80, 8'hFF);
        push_frame(8'h00, 8'h80, 8'h80, 8'h00);
        compare_rx("wrap");
        repeat (3) @(negedge clk);
        check("wrap_seq", 32'(seq1), 32'd1);

        // reset in the middle of a data bit aborts the frame at once
        start_frame(0);
        repeat (8) @(negedge clk);
        check("pre_rst_ser", 32'(ser4), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ser", 32'(ser4), 32'd1);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_seq", 32'(seq4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b0 = busy_cnt4;
        repeat (100) @(negedge clk);
        check("post_rst_quiet", 32'(busy_cnt4 - b0), 32'd0);
        check("post_rst_ser", 32'(ser4), 32'd1);
        start_frame(0);
        recv_bytes(0, 5);
        push_frame(8'h00, 8'h01, 8'h02, 8'h03);
        compare_rx("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
